// File: rtl/lc3b_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : lc3b_mem_pkg                                                     |
// | Purpose : Shared state encoding and request-field constants for the LC-3b  |
// |           memory responder.                                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic WE_READ  = 1'b0;
  localparam logic WE_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// +----------------------------------------------------------------------------+
// | Module  : mem_responder_if                                                 |
// | Purpose : MAR/MDR request bus and ready/read-data return path between the  |
// |           LC-3b datapath (master) and the memory responder (slave).        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_responder_if #(
  parameter int ADDR_W = 16
);

  logic              mio_en;
  logic [ADDR_W-1:0] addr;
  logic              size;
  logic              we;
  logic [15:0]       wdata;
  logic              r;
  logic [15:0]       rdata;
  logic              unaligned;

  modport master (
    output mio_en, addr, size, we, wdata,
    input  r, rdata, unaligned
  );

  modport slave (
    input  mio_en, addr, size, we, wdata,
    output r, rdata, unaligned
  );

endinterface

`default_nettype wire

// File: rtl/mem_array.sv
// +----------------------------------------------------------------------------+
// | Module  : mem_array                                                        |
// | Purpose : Two byte-lane RAMs with per-lane write enables and combinational |
// |           read; contents are not reset.                                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [1:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  // lane 0 holds the low byte (even address), lane 1 the high byte
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[g]) begin
        mem[idx] <= wdata[g*8 +: 8];
      end
    end

    assign rdata[g*8 +: 8] = mem[idx];
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// +----------------------------------------------------------------------------+
// | Module  : mem_responder                                                    |
// | Purpose : LC-3b memory-side responder with programmable wait states and a  |
// |           one-cycle ready pulse. Optional MEM_UNALIGNED_TRAP_EN flags and  |
// |           suppresses unaligned word accesses.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_responder
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_a0;
  logic             cap_size;
  logic             cap_we;
  logic [15:0]      cap_wdata;
  logic             r_q;
  logic [15:0]      rdata_q;
  logic             unal_q;

  logic             fire;
  logic             trap;
  logic [1:0]       lane_we;
  logic [15:0]      lane_wdata;
  logic [15:0]      arr_rdata;
  logic             unused_addr_hi;

  // Upper address bits alias onto the array.
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+1];

  assign fire = (state == BUSY) && (cnt == '0);

`ifdef MEM_UNALIGNED_TRAP_EN
  assign trap = (cap_size == SIZE_WORD) && cap_a0;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    lane_we = 2'b00;
    if (fire && (cap_we == WE_WRITE) && !trap) begin
      if (cap_size == SIZE_WORD) begin
        lane_we = 2'b11;
      end else begin
        lane_we = cap_a0 ? 2'b10 : 2'b01;
      end
    end
  end

  // A byte write replicates the low byte so either lane can take it.
  assign lane_wdata = (cap_size == SIZE_WORD) ? cap_wdata : {cap_wdata[7:0], cap_wdata[7:0]};

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (lane_we),
    .idx   (cap_idx),
    .wdata (lane_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_a0    <= 1'b0;
      cap_size  <= SIZE_BYTE;
      cap_we    <= WE_READ;
      cap_wdata <= 16'h0000;
      r_q       <= 1'b0;
      rdata_q   <= 16'h0000;
      unal_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          r_q    <= 1'b0;
          unal_q <= 1'b0;
          if (bus.mio_en) begin
            cap_idx   <= bus.addr[IDX_W:1];
            cap_a0    <= bus.addr[0];
            cap_size  <= bus.size;
            cap_we    <= bus.we;
            cap_wdata <= bus.wdata;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state  <= DONE;
            r_q    <= 1'b1;
            unal_q <= trap;
            if (cap_we == WE_READ) begin
              rdata_q <= trap ? 16'h0000 : arr_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_q    <= 1'b0;
          unal_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          r_q    <= 1'b0;
          unal_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.r         = r_q;
  assign bus.rdata     = rdata_q;
  assign bus.unaligned = unal_q;

endmodule

`default_nettype wire
